wb_port_arbiter: RTL

- Owns the single register-file write port.
- Shares that port between the in-order WB stage and a multi-cycle MDU (mul/div) completion path.
- Holds a scoreboard of MDU destination registers still pending and raises a decode stall on RAW/WAW hazards.
- Buffers MDU results in a small FIFO until a free write slot appears. Sits between the WB stage, the MDU and reg_file in decode.

---
 rtl/wb_port_arbiter.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//
// Owns the single register-file write port and shares it between the in-order
// WB stage and the multi-cycle MDU completion path. MDU results wait in a small
// FIFO until the WB stage leaves a write slot free. A scoreboard of pending MDU
// destinations drives the decode stall for RAW/WAW hazards.
//
// Optional feature (macro WBA_STARVE_GUARD_EN): a starvation counter raises
// wb_hold once a queued result has waited StarveLimit WB-busy cycles. Without
// the macro wb_hold is tied low and a queued result may wait indefinitely.
//
// Ports:
//   brq_clk, brq_rst_n            clock, asynchronous active-low reset
//   pipe_wb_en/addr/data          WB stage write request
//   mdu_issue_valid/rd/ready      MDU dispatch handshake from decode
//   mdu_done_valid/rd/data/ready  MDU result handshake
//   idu_rs1, idu_rs2              decode source register indices
//   sb_stall                      decode stall (RAW on pending reg, blocked issue)
//   rf_wen/rf_waddr/rf_wdata      register-file write port
//   mdu_wb_valid                  queue head is popped this cycle
//   wb_hold                       WB-stage bubble request (starve guard)
//   pending                       scoreboard, bit i = x_i awaiting MDU write
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int unsigned DataWidth    = 32,
    parameter int unsigned RegAddrWidth = 5,
    parameter int unsigned MdqDepth     = 2,
    parameter int unsigned StarveLimit  = 4
) (
    input  logic                    brq_clk,
    input  logic                    brq_rst_n,
    input  logic                    pipe_wb_en,
    input  logic [RegAddrWidth-1:0] pipe_wb_addr,
    input  logic [DataWidth-1:0]    pipe_wb_data,
    input  logic                    mdu_issue_valid,
    input  logic [RegAddrWidth-1:0] mdu_issue_rd,
    output logic                    mdu_issue_ready,
    input  logic                    mdu_done_valid,
    input  logic [RegAddrWidth-1:0] mdu_done_rd,
    input  logic [DataWidth-1:0]    mdu_done_data,
    output logic                    mdu_done_ready,
    input  logic [RegAddrWidth-1:0] idu_rs1,
    input  logic [RegAddrWidth-1:0] idu_rs2,
    output logic                    sb_stall,
    output logic                    rf_wen,
    output logic [RegAddrWidth-1:0] rf_waddr,
    output logic [DataWidth-1:0]    rf_wdata,
    output logic                    mdu_wb_valid,
    output logic                    wb_hold,
    output logic [31:0]             pending
);

    localparam int unsigned PtrW = (MdqDepth > 1) ? $clog2(MdqDepth) : 1;
    localparam int unsigned CntW = $clog2(MdqDepth + 1);

    // Result queue storage and state
    logic [RegAddrWidth-1:0] r_q_rd   [MdqDepth];
    logic [DataWidth-1:0]    r_q_data [MdqDepth];
    logic [PtrW-1:0]         r_wptr;
    logic [PtrW-1:0]         r_rptr;
    logic [CntW-1:0]         r_qcnt;
    logic [CntW-1:0]         r_outst;
    logic [31:0]             r_pending;

    logic                    w_wb_used;
    logic                    w_wb_win;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_q_empty;
    logic                    w_q_full;
    logic                    w_issue_acc;
    logic                    w_issue_waw;
    logic                    w_rs1_haz;
    logic                    w_rs2_haz;
    logic [RegAddrWidth-1:0] w_head_rd;
    logic [DataWidth-1:0]    w_head_data;
    logic [31:0]             w_pending_nxt;

`ifdef WBA_STARVE_GUARD_EN
    localparam int unsigned StW = $clog2(StarveLimit + 1);
    logic [StW-1:0]          r_starve;
    logic [StW-1:0]          w_starve_nxt;
    logic                    r_hold;
`endif

    // WB slot use is gated by reset so no write leaves the port while in reset.
    assign w_wb_used   = brq_rst_n & pipe_wb_en & (pipe_wb_addr != '0);
    assign w_q_empty   = (r_qcnt == '0);
    assign w_q_full    = (r_qcnt == CntW'(MdqDepth));
    assign w_head_rd   = r_q_rd[r_rptr];
    assign w_head_data = r_q_data[r_rptr];

`ifdef WBA_STARVE_GUARD_EN
    // During hold the queue owns the port even if WB still (illegally) writes.
    assign w_pop    = !w_q_empty & (!w_wb_used | r_hold);
    assign w_wb_win = w_wb_used & !r_hold;
`else
    assign w_pop    = !w_q_empty & !w_wb_used;
    assign w_wb_win = w_wb_used;
`endif

    assign mdu_done_ready = !w_q_full | w_pop;
    assign w_push         = mdu_done_valid & mdu_done_ready;

    // Second term blocks a WAW on a destination still awaiting its MDU write.
    assign w_issue_waw     = (mdu_issue_rd != '0) & r_pending[mdu_issue_rd];
    assign mdu_issue_ready = (r_outst < CntW'(MdqDepth)) & !w_issue_waw;
    assign w_issue_acc     = mdu_issue_valid & mdu_issue_ready;

    assign w_rs1_haz = (idu_rs1 != '0) & r_pending[idu_rs1];
    assign w_rs2_haz = (idu_rs2 != '0) & r_pending[idu_rs2];
    assign sb_stall  = w_rs1_haz | w_rs2_haz | (mdu_issue_valid & !mdu_issue_ready);

    assign mdu_wb_valid = w_pop;
    assign pending      = r_pending;

    // Write-port mux: WB first, then queue head. A head with rd=0 pops silently.
    always_comb begin
        rf_wen   = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (w_wb_win) begin
            rf_wen   = 1'b1;
            rf_waddr = pipe_wb_addr;
            rf_wdata = pipe_wb_data;
        end else if (w_pop) begin
            rf_wen   = (w_head_rd != '0);
            rf_waddr = w_head_rd;
            rf_wdata = w_head_data;
        end
    end

    // Clear on pop, then set on issue; WAW blocking keeps the two on
    // different registers, so applying both in sequence is safe.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop && (w_head_rd != '0)) begin
            w_pending_nxt[w_head_rd] = 1'b0;
        end
        if (w_issue_acc && (mdu_issue_rd != '0)) begin
            w_pending_nxt[mdu_issue_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge brq_clk or negedge brq_rst_n) begin
        if (!brq_rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_qcnt    <= '0;
            r_outst   <= '0;
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_qcnt <= r_qcnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_qcnt <= r_qcnt - 1'b1;
            end
            if (w_issue_acc && !w_pop) begin
                r_outst <= r_outst + 1'b1;
            end else if (w_pop && !w_issue_acc && (r_outst != '0)) begin
                r_outst <= r_outst - 1'b1;
            end
        end
    end

    // Payload storage needs no reset: it is only read when r_qcnt != 0.
    always_ff @(posedge brq_clk) begin
        if (w_push) begin
            r_q_rd[r_wptr]   <= mdu_done_rd;
            r_q_data[r_wptr] <= mdu_done_data;
        end
    end

`ifdef WBA_STARVE_GUARD_EN
    always_comb begin
        w_starve_nxt = r_starve;
        if (w_pop || w_q_empty) begin
            w_starve_nxt = '0;
        end else if (w_wb_used && (r_starve != StW'(StarveLimit))) begin
            w_starve_nxt = r_starve + 1'b1;
        end
    end

    always_ff @(posedge brq_clk or negedge brq_rst_n) begin
        if (!brq_rst_n) begin
            r_starve <= '0;
            r_hold   <= 1'b0;
        end else begin
            r_starve <= w_starve_nxt;
            if (w_pop) begin
                r_hold <= 1'b0;
            end else if (w_starve_nxt == StW'(StarveLimit)) begin
                r_hold <= 1'b1;
            end
        end
    end

    assign wb_hold = r_hold;

    // The pipeline must not present a WB write while a hold is requested.
    a_no_wb_during_hold : assert property (
        @(posedge brq_clk) disable iff (!brq_rst_n)
        r_hold |-> !w_wb_used
    );
`else
    assign wb_hold = 1'b0;
`endif

endmodule
